ysyx_23060203_mem_arb: RTL and testbench

//  Arbitrates one shared memory port between the IFU (instruction fetch) and the
//  EXU load/store path (LSU). It serialises requests, one outstanding transaction at a

---
 rtl/ysyx_23060203_mem_arb_if.sv | 54 +++++
 rtl/ysyx_23060203_mem_arb.sv | 206 ++++++++++++++++++++
 tb/tb_ysyx_23060203_mem_arb.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060203_mem_arb_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ysyx_23060203_mem_arb_if : IFU / LSU / memory handshake bundle         |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface ysyx_23060203_mem_arb_if;
  logic        ifu_req_valid;
  logic [31:0] ifu_req_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic [2:0]  lsu_req_func;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [2:0]  mem_req_func;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  // master: the arbiter, which masters the shared memory port
  modport master (
    input  ifu_req_valid, ifu_req_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    input  lsu_req_valid, lsu_req_wen, lsu_req_func, lsu_req_addr, lsu_req_wdata,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    output mem_req_valid, mem_req_wen, mem_req_func, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );

  // slave: requesters plus memory, seen from the outside of the arbiter
  modport slave (
    output ifu_req_valid, ifu_req_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
    output lsu_req_valid, lsu_req_wen, lsu_req_func, lsu_req_addr, lsu_req_wdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
    input  mem_req_valid, mem_req_wen, mem_req_func, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060203_mem_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ysyx_23060203_mem_arb : IFU/LSU arbiter for one shared memory port,    |
// | one outstanding transaction, watchdog. Macro: ARB_ROUND_ROBIN_EN       |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module ysyx_23060203_mem_arb #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic                      clk,
  input  logic                      rstn,
  ysyx_23060203_mem_arb_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_grant_ifu;
  logic        w_grant_lsu;
  logic        w_handshake;
  logic        w_timeout;
  logic        w_active;

  logic        r_owner_lsu;
  logic        r_req_wen;
  logic [2:0]  r_req_func;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [31:0] r_resp_data;
  logic        r_resp_err;

  assign w_active    = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_handshake = (r_state == S_IDLE) && (w_grant_ifu || w_grant_lsu);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_lsu;

  // On contention the requester that was not served last wins.
  always_comb begin
    w_grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !r_last_lsu);
    w_grant_ifu = bus.ifu_req_valid && !w_grant_lsu;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last_lsu <= 1'b1;
    end else if (w_handshake) begin
      r_last_lsu <= w_grant_lsu;
    end
  end
`else
  // LSU first: the instruction in flight must retire before the next fetch.
  always_comb begin
    w_grant_lsu = bus.lsu_req_valid;
    w_grant_ifu = bus.ifu_req_valid && !bus.lsu_req_valid;
  end
`endif

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
          r_cnt <= '0;
        end else if (w_active) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // Fires on the last allowed REQ/WAIT cycle so RESP lands exactly TIMEOUT cycles after REQ entry.
      assign w_timeout = w_active && (r_cnt == c_to_last);
    end else begin : g_no_wdog
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_owner_lsu <= 1'b0;
      r_req_wen   <= 1'b0;
      r_req_func  <= 3'b000;
      r_req_addr  <= 32'h0;
      r_req_wdata <= 32'h0;
      r_resp_data <= 32'h0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_owner_lsu <= w_grant_lsu;
        if (w_grant_lsu) begin
          r_req_wen   <= bus.lsu_req_wen;
          r_req_func  <= bus.lsu_req_func;
          r_req_addr  <= bus.lsu_req_addr;
          r_req_wdata <= bus.lsu_req_wdata;
        end else begin
          r_req_wen   <= 1'b0;
          r_req_func  <= 3'b010;
          r_req_addr  <= bus.ifu_req_addr;
          r_req_wdata <= 32'h0;
        end
      end

      // A genuine response beats an expiry landing on the same cycle.
      if ((r_state == S_WAIT) && bus.mem_resp_valid) begin
        r_resp_data <= r_req_wen ? 32'h0 : bus.mem_resp_data;
        r_resp_err  <= bus.mem_resp_err;
      end else if (w_timeout) begin
        r_resp_data <= 32'h0;
        r_resp_err  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    bus.ifu_req_ready  = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_data  = 32'h0;
    bus.ifu_resp_err   = 1'b0;
    bus.lsu_req_ready  = 1'b0;
    bus.lsu_resp_valid = 1'b0;
    bus.lsu_resp_data  = 32'h0;
    bus.lsu_resp_err   = 1'b0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_wen    = r_req_wen;
    bus.mem_req_func   = r_req_func;
    bus.mem_req_addr   = r_req_addr;
    bus.mem_req_wdata  = r_req_wdata;

    case (r_state)
      S_IDLE: begin
        bus.ifu_req_ready = w_grant_ifu;
        bus.lsu_req_ready = w_grant_lsu;
        if (w_handshake) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        bus.mem_req_valid = !w_timeout;
        if (w_timeout) begin
          w_state_nxt = S_RESP;
        end else if (bus.mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (r_owner_lsu) begin
          bus.lsu_resp_valid = 1'b1;
          bus.lsu_resp_data  = r_resp_data;
          bus.lsu_resp_err   = r_resp_err;
        end else begin
          bus.ifu_resp_valid = 1'b1;
          bus.ifu_resp_data  = r_resp_data;
          bus.ifu_resp_err   = r_resp_err;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs read as zero for the whole time reset is asserted, not only after its edge.
    if (!rstn) begin
      bus.ifu_req_ready  = 1'b0;
      bus.ifu_resp_valid = 1'b0;
      bus.ifu_resp_data  = 32'h0;
      bus.ifu_resp_err   = 1'b0;
      bus.lsu_req_ready  = 1'b0;
      bus.lsu_resp_valid = 1'b0;
      bus.lsu_resp_data  = 32'h0;
      bus.lsu_resp_err   = 1'b0;
      bus.mem_req_valid  = 1'b0;
      bus.mem_req_wen    = 1'b0;
      bus.mem_req_func   = 3'b000;
      bus.mem_req_addr   = 32'h0;
      bus.mem_req_wdata  = 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060203_mem_arb.sv
`default_nettype none
// Bench for ysyx_23060203_mem_arb: directed stimulus, literal spot checks and a
// transaction-level reference model compared against every output each cycle.
module tb_ysyx_23060203_mem_arb;
  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060203_mem_arb_if bus();

  ysyx_23060203_mem_arb #(.TIMEOUT(TO), .CNT_W(9)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  int tests = 0;
  int fails = 0;
  bit lsu_first;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 = nobody, 1 = IFU, 2 = LSU
  function automatic int arb_pick(input bit iv, input bit lv, input bit last_lsu);
    if (iv && lv) return (RR && last_lsu) ? 1 : 2;
    if (lv) return 2;
    if (iv) return 1;
    return 0;
  endfunction

  // Reference model: a transaction is either absent, waiting on memory, or delivering.
  bit          m_busy, m_owner_lsu, m_sent, m_done, m_err, m_last_lsu;
  bit          m_wen;
  bit [2:0]    m_func;
  bit [31:0]   m_addr, m_wdata, m_data;
  int          m_age;

  always @(negedge clk) begin : model
    int          pick;
    bit          expire;
    logic [31:0] e_ir, e_iv, e_id, e_ie, e_lr, e_lv, e_ld, e_le, e_mv;
    e_ir = 0; e_iv = 0; e_id = 0; e_ie = 0;
    e_lr = 0; e_lv = 0; e_ld = 0; e_le = 0; e_mv = 0;
    pick   = arb_pick(bus.ifu_req_valid, bus.lsu_req_valid, m_last_lsu);
    expire = (TO > 0) && (m_age + 1 == TO);
    if (rstn) begin
      if (!m_busy) begin
        e_ir = (pick == 1);
        e_lr = (pick == 2);
      end else if (m_done) begin
        if (m_owner_lsu) begin e_lv = 1; e_ld = m_data; e_le = m_err; end
        else             begin e_iv = 1; e_id = m_data; e_ie = m_err; end
      end else begin
        e_mv = !m_sent && !expire;
      end
    end
    chk("m_ifu_ready",  bus.ifu_req_ready,  e_ir);
    chk("m_ifu_rvalid", bus.ifu_resp_valid, e_iv);
    chk("m_ifu_rdata",  bus.ifu_resp_data,  e_id);
    chk("m_ifu_rerr",   bus.ifu_resp_err,   e_ie);
    chk("m_lsu_ready",  bus.lsu_req_ready,  e_lr);
    chk("m_lsu_rvalid", bus.lsu_resp_valid, e_lv);
    chk("m_lsu_rdata",  bus.lsu_resp_data,  e_ld);
    chk("m_lsu_rerr",   bus.lsu_resp_err,   e_le);
    chk("m_mem_valid",  bus.mem_req_valid,  e_mv);
    chk("m_mem_wen",    bus.mem_req_wen,    rstn ? 32'(m_wen)  : 32'h0);
    chk("m_mem_func",   bus.mem_req_func,   rstn ? 32'(m_func) : 32'h0);
    chk("m_mem_addr",   bus.mem_req_addr,   rstn ? m_addr      : 32'h0);
    chk("m_mem_wdata",  bus.mem_req_wdata,  rstn ? m_wdata     : 32'h0);

    // advance to the state seen after the next rising edge
    if (!rstn) begin
      m_busy = 0; m_done = 0; m_last_lsu = 1;
      m_wen = 0; m_func = 0; m_addr = 0; m_wdata = 0;
    end else if (!m_busy) begin
      if (pick != 0) begin
        m_busy = 1; m_sent = 0; m_done = 0; m_age = 0;
        m_owner_lsu = (pick == 2);
        m_last_lsu  = (pick == 2);
        if (pick == 2) begin
          m_wen = bus.lsu_req_wen; m_func = bus.lsu_req_func;
          m_addr = bus.lsu_req_addr; m_wdata = bus.lsu_req_wdata;
        end else begin
          m_wen = 0; m_func = 3'b010; m_addr = bus.ifu_req_addr; m_wdata = 0;
        end
      end
    end else if (m_done) begin
      m_busy = 0; m_done = 0;
    end else begin
      if (!m_sent) begin
        if (expire) begin m_done = 1; m_data = 0; m_err = 1; end
        else if (bus.mem_req_ready) m_sent = 1;
      end else if (bus.mem_resp_valid) begin
        m_done = 1; m_data = m_wen ? 32'h0 : bus.mem_resp_data; m_err = bus.mem_resp_err;
      end else if (expire) begin
        m_done = 1; m_data = 0; m_err = 1;
      end
      m_age++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Runs one transaction from an IDLE cycle whose requests the caller has set up.
  task automatic serve(input bit is_lsu, input logic [31:0] rdata, input bit rerr, input string tag);
    bus.mem_req_ready = 1'b1;
    #1;
    chk({tag, "_ifu_ready"}, bus.ifu_req_ready, {31'd0, !is_lsu});
    chk({tag, "_lsu_ready"}, bus.lsu_req_ready, {31'd0, is_lsu});
    cyc(1); #1;
    chk({tag, "_busy_ready"}, {31'd0, bus.ifu_req_ready | bus.lsu_req_ready}, 32'd0);
    cyc(1);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = rdata; bus.mem_resp_err = rerr;
    cyc(1);
    bus.mem_resp_valid = 1'b0;
    if (is_lsu) bus.lsu_req_valid = 1'b0; else bus.ifu_req_valid = 1'b0;
    #1;
    chk({tag, "_ifu_rvalid"}, bus.ifu_resp_valid, {31'd0, !is_lsu});
    chk({tag, "_lsu_rvalid"}, bus.lsu_resp_valid, {31'd0, is_lsu});
    chk({tag, "_rdata"}, is_lsu ? bus.lsu_resp_data : bus.ifu_resp_data, rdata);
    chk({tag, "_rerr"}, {31'd0, is_lsu ? bus.lsu_resp_err : bus.ifu_resp_err}, {31'd0, rerr});
    cyc(1);
  endtask

  initial begin
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0000;
    bus.lsu_req_valid = 1'b0; bus.lsu_req_wen = 1'b0; bus.lsu_req_func = 3'b000;
    bus.lsu_req_addr = 32'h0; bus.lsu_req_wdata = 32'h0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = 32'h0; bus.mem_resp_err = 1'b0;
    cyc(3);
    chk("rst_ifu_ready", bus.ifu_req_ready, 32'd0);
    chk("rst_mem_valid", bus.mem_req_valid, 32'd0);

    // 1: IFU fetch, 1-cycle memory, response in the 4th cycle
    rstn = 1'b1;
    #1;
    chk("t1_ready", bus.ifu_req_ready, 32'd1);
    cyc(1);
    bus.ifu_req_valid = 1'b0; bus.ifu_req_addr = 32'h1234_5678; bus.mem_req_ready = 1'b1;
    #1;
    chk("t1_mvalid", bus.mem_req_valid, 32'd1);
    chk("t1_maddr", bus.mem_req_addr, 32'h8000_0000);
    chk("t1_mfunc", bus.mem_req_func, 32'd2);
    chk("t1_mwen", bus.mem_req_wen, 32'd0);
    cyc(1);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h0000_0413;
    #1;
    chk("t1_early", bus.ifu_resp_valid, 32'd0);
    cyc(1);
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("t1_rvalid", bus.ifu_resp_valid, 32'd1);
    chk("t1_rdata", bus.ifu_resp_data, 32'h0000_0413);
    chk("t1_rerr", bus.ifu_resp_err, 32'd0);
    cyc(1);
    chk("t1_pulse_end", bus.ifu_resp_valid, 32'd0);

    // 2: LSU store held in REQ for 5 cycles
    bus.mem_req_ready = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b1; bus.lsu_req_func = 3'd2;
    bus.lsu_req_addr = 32'h8000_1000; bus.lsu_req_wdata = 32'hDEAD_BEEF;
    #1;
    chk("t2_ready", bus.lsu_req_ready, 32'd1);
    cyc(1);
    bus.lsu_req_valid = 1'b0; bus.lsu_req_addr = 32'h0; bus.lsu_req_wdata = 32'h0;
    bus.lsu_req_wen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_hold_valid", bus.mem_req_valid, 32'd1);
      chk("t2_hold_addr", bus.mem_req_addr, 32'h8000_1000);
      chk("t2_hold_wdata", bus.mem_req_wdata, 32'hDEAD_BEEF);
      chk("t2_hold_wen", bus.mem_req_wen, 32'd1);
      cyc(1);
    end
    bus.mem_req_ready = 1'b1;
    cyc(1);
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h5555_5555;
    cyc(1);
    bus.mem_resp_valid = 1'b0;
    #1;
    chk("t2_rvalid", bus.lsu_resp_valid, 32'd1);
    chk("t2_rdata", bus.lsu_resp_data, 32'h0);
    cyc(1);

    // 3: contention from a fresh reset, two rounds
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    lsu_first = !RR;
    bus.lsu_req_wen = 1'b0; bus.lsu_req_func = 3'b010; bus.lsu_req_addr = 32'h8000_2000;
    bus.ifu_req_addr = 32'h8000_0004;
    for (int r = 0; r < 2; r++) begin
      bus.ifu_req_valid = 1'b1; bus.lsu_req_valid = 1'b1;
      serve(lsu_first, 32'hAAAA_0001 + r, 1'b0, "t3_first");
      serve(!lsu_first, 32'hBBBB_0001 + r, 1'b0, "t3_second");
    end

    // 4: watchdog, memory never accepts
    bus.mem_req_ready = 1'b0;
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0040;
    #1;
    chk("t4_ready", bus.ifu_req_ready, 32'd1);
    cyc(1);
    bus.ifu_req_valid = 1'b0;
    for (int k = 0; k < TO; k++) begin
      #1;
      chk("t4_no_resp", bus.ifu_resp_valid, 32'd0);
      chk("t4_mvalid", bus.mem_req_valid, {31'd0, k < TO - 1});
      cyc(1);
    end
    #1;
    chk("t4_rvalid", bus.ifu_resp_valid, 32'd1);
    chk("t4_rerr", bus.ifu_resp_err, 32'd1);
    chk("t4_rdata", bus.ifu_resp_data, 32'h0);
    bus.mem_req_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hBAD0_BAD0;
    cyc(2);
    bus.mem_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stale", {31'd0, bus.ifu_resp_valid | bus.lsu_resp_valid}, 32'd0);
      cyc(1);
    end

    // 5: reset while waiting on memory
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0080;
    cyc(1);
    bus.ifu_req_valid = 1'b0;
    cyc(1);
    rstn = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h1111_1111;
    #1;
    chk("t5_rst_mvalid", bus.mem_req_valid, 32'd0);
    chk("t5_rst_maddr", bus.mem_req_addr, 32'h0);
    cyc(1);
    rstn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t5_no_resp", {31'd0, bus.ifu_resp_valid | bus.lsu_resp_valid}, 32'd0);
      cyc(1);
      bus.mem_resp_valid = 1'b0;
    end
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0084;
    serve(1'b0, 32'h2222_2222, 1'b0, "t5_after");

    // 6: LSU load error, then a clean fetch
    bus.lsu_req_valid = 1'b1; bus.lsu_req_wen = 1'b0; bus.lsu_req_func = 3'b100;
    bus.lsu_req_addr = 32'h8000_3003;
    serve(1'b1, 32'hCAFE_BABE, 1'b1, "t6_err");
    bus.ifu_req_valid = 1'b1; bus.ifu_req_addr = 32'h8000_0088;
    serve(1'b0, 32'h0000_0013, 1'b0, "t6_next");

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
